// File: rtl/processor_pkg.sv
// Shared processor definitions: instruction memory geometry defaults and the
// program loader state encoding.
package processor_pkg;

    localparam int unsigned WORD_WIDTH_DEF      = 16;
    localparam int unsigned IMEM_ADDR_WIDTH_DEF = 11;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_HEADER,
        LD_LOAD,
        LD_CHECK,
        LD_RELEASE,
        LD_DONE,
        LD_ERROR
    } loader_state_t;

endpackage

// File: rtl/loader_checksum.sv
// Running XOR of the payload words of one load.
// Compiled only when LOADER_CHECKSUM_EN is defined; the loader instantiates it only then.
`ifdef LOADER_CHECKSUM_EN
module loader_checksum
    import processor_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] data,
    output logic [WORD_WIDTH-1:0] acc
);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ data;
        end
    end

endmodule
`endif

// File: rtl/program_loader.sv
// Streams a length-prefixed program image from the host into instruction memory while
// holding the processor in reset. Define LOADER_CHECKSUM_EN to require a trailing XOR checksum.
module program_loader
    import processor_pkg::*;
#(
    parameter int unsigned WORD_WIDTH      = WORD_WIDTH_DEF,
    parameter int unsigned IMEM_ADDR_WIDTH = IMEM_ADDR_WIDTH_DEF,
    parameter int unsigned RST_HOLD        = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [WORD_WIDTH-1:0]      in_data,
    output logic                       in_ready,
    output logic                       imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_WIDTH-1:0]      imem_wdata,
    output logic                       cpu_rst,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [IMEM_ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned CW = IMEM_ADDR_WIDTH + 1;
    localparam int unsigned HW = (WORD_WIDTH > CW) ? WORD_WIDTH : CW;
    localparam int unsigned TW = $clog2(RST_HOLD + 2);
    localparam logic [HW-1:0] DEPTH = HW'(1) << IMEM_ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t POST_LOAD = LD_CHECK;
`else
    localparam loader_state_t POST_LOAD = LD_RELEASE;
`endif

    loader_state_t state, state_nx;
    logic [CW-1:0] count;
    logic [CW-1:0] len;
    logic [TW-1:0] hold_cnt;
    logic [HW-1:0] hdr;
    logic          accept;
    logic          hdr_ok;
    logic          last_word;
    logic          hold_done;

    // Header compared in a width that can hold both the word and the memory depth.
    assign hdr       = HW'(in_data);
    assign hdr_ok    = (hdr != '0) && (hdr <= DEPTH);
    assign accept    = in_valid && in_ready;
    assign last_word = (count + CW'(1)) == len;
    assign hold_done = (32'(hold_cnt) + 32'd1) >= 32'(RST_HOLD);

    assign words_loaded = count;

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] csum;

    loader_checksum #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_checksum (
        .clk  (clk),
        .rst  (rst),
        .clear(start),
        .en   ((state == LD_LOAD) && accept),
        .data (in_data),
        .acc  (csum)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LD_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = LD_HEADER;
        end else begin
            case (state)
                LD_HEADER: begin
                    if (accept) state_nx = hdr_ok ? LD_LOAD : LD_ERROR;
                end
                LD_LOAD: begin
                    if (accept && last_word) state_nx = POST_LOAD;
                end
`ifdef LOADER_CHECKSUM_EN
                LD_CHECK: begin
                    if (accept) state_nx = (in_data == csum) ? LD_RELEASE : LD_ERROR;
                end
`endif
                // The cycle carrying the final write does not count toward the hold.
                LD_RELEASE: begin
                    if (!imem_we && hold_done) state_nx = LD_DONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_rst  = 1'b1;
        case (state)
            LD_HEADER, LD_LOAD, LD_CHECK: begin
                in_ready = !start;
                busy     = 1'b1;
            end
            LD_RELEASE: busy = 1'b1;
            LD_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
            end
            LD_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count      <= '0;
            len        <= '0;
            hold_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                count    <= '0;
                hold_cnt <= '0;
            end else begin
                if (state == LD_HEADER && accept && hdr_ok) begin
                    len   <= hdr[CW-1:0];
                    count <= '0;
                end
                if (state == LD_LOAD && accept) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= count[IMEM_ADDR_WIDTH-1:0];
                    imem_wdata <= in_data;
                    count      <= count + 1'b1;
                end
                if (state == LD_RELEASE && !imem_we) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end else begin
                    hold_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized loads
// checked against a queue-based model of the expected memory writes and timing.
module tb_program_loader;

    localparam int unsigned WW       = 16;
    localparam int unsigned AW       = 11;
    localparam int unsigned RST_HOLD = 2;
`ifdef LOADER_CHECKSUM_EN
    localparam int unsigned DONE_LAT = RST_HOLD + 1;
`else
    localparam int unsigned DONE_LAT = RST_HOLD + 2;
`endif

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic [WW-1:0] in_data  = '0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [WW-1:0] imem_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    program_loader #(
        .WORD_WIDTH     (WW),
        .IMEM_ADDR_WIDTH(AW),
        .RST_HOLD       (RST_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_rst     (cpu_rst),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log captured from the memory port
    logic [AW-1:0] log_addr [0:4095];
    logic [WW-1:0] log_data [0:4095];
    int unsigned   log_cyc  [0:4095];
    int unsigned   wr_cnt = 0;

    always @(negedge clk) begin
        if (imem_we === 1'b1 && wr_cnt < 4096) begin
            log_addr[wr_cnt] <= imem_addr;
            log_data[wr_cnt] <= imem_wdata;
            log_cyc[wr_cnt]  <= cyc;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    logic [WW-1:0] payload [$];
    int unsigned   acc_log [$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start    = 1'b1;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        acc_log.delete();
    endtask

    task automatic send_word(input logic [WW-1:0] w, input int unsigned gaps);
        bit ok;
        ok = 1'b0;
        for (int unsigned g = 0; g < gaps; g++) begin
            in_valid = 1'b0;
            in_data  = WW'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = w;
        for (int unsigned t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                acc_log.push_back(cyc);
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL handshake: word %h not accepted within 40 cycles, in_ready=%b", w, in_ready);
        end
    endtask

    task automatic send_checksum();
`ifdef LOADER_CHECKSUM_EN
        logic [WW-1:0] x;
        x = '0;
        foreach (payload[i]) x ^= payload[i];
        send_word(x, 0);
`endif
    endtask

    // mode 0: in_valid held high, 1: valid every other cycle, 2: random gaps
    task automatic drive_load(input int unsigned mode);
        pulse_start();
        send_word(WW'(payload.size()), 0);
        foreach (payload[i]) begin
            send_word(payload[i], (mode == 1) ? 1 : (mode == 2) ? $urandom_range(0, 2) : 0);
        end
        send_checksum();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int unsigned dcyc);
        int unsigned n;
        n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        dcyc = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (in_ready !== 1'b0 || cpu_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b cpu_rst=%b busy=%b done=%b error=%b, required 0 1 0 0 0",
                     in_ready, cpu_rst, busy, done, error);
        end
        n_tests++;
        if (imem_we !== 1'b0 || words_loaded !== '0) begin
            n_fail++;
            $display("FAIL reset_data: imem_we=%b words_loaded=%0d, required 0 0", imem_we, words_loaded);
        end
        rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h5A5A;
        repeat (2) tick();
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || cpu_rst !== 1'b1 || wr_cnt != 0) begin
            n_fail++;
            $display("FAIL idle_noop: in_ready=%b busy=%b cpu_rst=%b writes=%0d, required 0 0 1 0",
                     in_ready, busy, cpu_rst, wr_cnt);
        end
    endtask

    task automatic test_load();
        int unsigned base;
        int unsigned dcyc;
        payload = '{16'h1111, 16'h2222, 16'h3333};
        base = wr_cnt;
        drive_load(0);
        wait_done(dcyc);
        n_tests++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: done=%b cpu_rst=%b busy=%b in_ready=%b, required 1 0 0 0",
                     done, cpu_rst, busy, in_ready);
        end
        n_tests++;
        if (words_loaded !== 12'd3) begin
            n_fail++;
            $display("FAIL load_words: words_loaded=%0d required 3", words_loaded);
        end
        n_tests++;
        if (wr_cnt - base != 3) begin
            n_fail++;
            $display("FAIL load_count: writes=%0d required 3", wr_cnt - base);
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                n_tests++;
                if (log_addr[base+i] !== AW'(i) || log_data[base+i] !== payload[i] ||
                    log_cyc[base+i] != acc_log[i+1] + 1) begin
                    n_fail++;
                    $display("FAIL load_write%0d: addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                             i, log_addr[base+i], log_data[base+i], log_cyc[base+i], i, payload[i], acc_log[i+1] + 1);
                end
            end
        end
        n_tests++;
        if (dcyc != acc_log[acc_log.size()-1] + DONE_LAT) begin
            n_fail++;
            $display("FAIL load_latency: done at cycle %0d, required %0d", dcyc, acc_log[acc_log.size()-1] + DONE_LAT);
        end
    endtask

    task automatic test_backpressure();
        int unsigned base;
        int unsigned dcyc;
        payload = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
        base = wr_cnt;
        drive_load(1);
        wait_done(dcyc);
        n_tests++;
        if (done !== 1'b1 || words_loaded !== 12'd4 || wr_cnt - base != 4) begin
            n_fail++;
            $display("FAIL bp_summary: done=%b words_loaded=%0d writes=%0d, required 1 4 4",
                     done, words_loaded, wr_cnt - base);
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                n_tests++;
                if (log_addr[base+i] !== AW'(i) || log_data[base+i] !== payload[i]) begin
                    n_fail++;
                    $display("FAIL bp_write%0d: addr=%0d data=%h, required addr=%0d data=%h",
                             i, log_addr[base+i], log_data[base+i], i, payload[i]);
                end
            end
        end
    endtask

    task automatic test_bad_header();
        int unsigned base;
        base = wr_cnt;
        pulse_start();
        send_word(16'd0, 0);
        in_valid = 1'b0;
        n_tests++;
        if (error !== 1'b1 || busy !== 1'b0 || cpu_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL hdr0_error: error=%b busy=%b cpu_rst=%b, required 1 0 1", error, busy, cpu_rst);
        end
        in_valid = 1'b1;
        in_data  = 16'h0003;
        repeat (3) tick();
        in_valid = 1'b0;
        n_tests++;
        if (error !== 1'b1 || in_ready !== 1'b0 || wr_cnt != base) begin
            n_fail++;
            $display("FAIL hdr0_sticky: error=%b in_ready=%b writes=%0d, required 1 0 0", error, in_ready, wr_cnt - base);
        end
        pulse_start();
        send_word(16'd2049, 0);
        in_valid = 1'b0;
        n_tests++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hdr2049_error: error=%b busy=%b, required 1 0", error, busy);
        end
        pulse_start();
        send_word(16'd2048, 0);
        in_valid = 1'b0;
        n_tests++;
        if (error !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1 || wr_cnt != base) begin
            n_fail++;
            $display("FAIL hdr2048_accept: error=%b busy=%b in_ready=%b writes=%0d, required 0 1 1 0",
                     error, busy, in_ready, wr_cnt - base);
        end
    endtask

    task automatic test_restart();
        int unsigned   base;
        int unsigned   dcyc;
        logic [WW-1:0] w0;
        logic [WW-1:0] w1;
        w0 = WW'($urandom);
        w1 = WW'($urandom);
        base = wr_cnt;
        pulse_start();
        send_word(16'd5, 0);
        send_word(w0, 0);
        send_word(w1, 0);
        start    = 1'b1;
        in_data  = 16'hDEAD;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL start_priority: in_ready=%b required 0", in_ready);
        end
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (words_loaded !== '0 || busy !== 1'b1 || cpu_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear: words_loaded=%0d busy=%b cpu_rst=%b, required 0 1 1",
                     words_loaded, busy, cpu_rst);
        end
        payload = '{16'hABCD};
        acc_log.delete();
        send_word(16'd1, 0);
        send_word(16'hABCD, 0);
        send_checksum();
        in_valid = 1'b0;
        wait_done(dcyc);
        n_tests++;
        if (done !== 1'b1 || words_loaded !== 12'd1) begin
            n_fail++;
            $display("FAIL restart_done: done=%b words_loaded=%0d, required 1 1", done, words_loaded);
        end
        n_tests++;
        if (wr_cnt - base != 3 || log_addr[base] !== 11'd0 || log_data[base] !== w0 ||
            log_addr[base+1] !== 11'd1 || log_data[base+1] !== w1 ||
            log_addr[base+2] !== 11'd0 || log_data[base+2] !== 16'hABCD) begin
            n_fail++;
            $display("FAIL restart_writes: count=%0d last addr=%0d data=%h, required 3 writes ending addr 0 data abcd",
                     wr_cnt - base, log_addr[wr_cnt-1], log_data[wr_cnt-1]);
        end
    endtask

    task automatic test_reset_midload();
        int unsigned   base;
        logic [WW-1:0] p [3];
        for (int unsigned i = 0; i < 3; i++) p[i] = WW'($urandom) | 16'h0001;
        base = wr_cnt;
        pulse_start();
        send_word(16'd5, 0);
        send_word(p[0], 0);
        send_word(p[1], 0);
        rst     = 1'b0;
        in_data = p[2];
        tick();
        n_tests++;
        if (busy !== 1'b0 || cpu_rst !== 1'b1 || in_ready !== 1'b0 || words_loaded !== '0 ||
            done !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ctrl: busy=%b cpu_rst=%b in_ready=%b words_loaded=%0d done=%b error=%b, required 0 1 0 0 0 0",
                     busy, cpu_rst, in_ready, words_loaded, done, error);
        end
        n_tests++;
        if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== '0) begin
            n_fail++;
            $display("FAIL midrst_mem: imem_we=%b imem_addr=%0d imem_wdata=%h, required 0 0 0",
                     imem_we, imem_addr, imem_wdata);
        end
        rst = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || wr_cnt - base != 2 ||
            log_data[base] !== p[0] || log_data[base+1] !== p[1]) begin
            n_fail++;
            $display("FAIL midrst_discard: busy=%b in_ready=%b writes=%0d, required 0 0 2",
                     busy, in_ready, wr_cnt - base);
        end
    endtask

    task automatic test_checksum();
`ifdef LOADER_CHECKSUM_EN
        int unsigned dcyc;
        payload = '{16'h00F0, 16'h0F00};
        pulse_start();
        send_word(16'd2, 0);
        send_word(16'h00F0, 0);
        send_word(16'h0F00, 0);
        send_word(16'h0FF0, 0);
        in_valid = 1'b0;
        wait_done(dcyc);
        n_tests++;
        if (done !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL csum_good: done=%b error=%b, required 1 0", done, error);
        end
        pulse_start();
        send_word(16'd2, 0);
        send_word(16'h00F0, 0);
        send_word(16'h0F00, 0);
        send_word(16'h0000, 0);
        in_valid = 1'b0;
        n_tests++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL csum_bad: error=%b done=%b cpu_rst=%b, required 1 0 1", error, done, cpu_rst);
        end
`endif
    endtask

    task automatic test_random();
        int unsigned base;
        int unsigned dcyc;
        int unsigned n;
        int unsigned mode;
        for (int unsigned it = 0; it < 10; it++) begin
            n    = $urandom_range(1, 12);
            mode = $urandom_range(0, 2);
            payload.delete();
            for (int unsigned i = 0; i < n; i++) payload.push_back(WW'($urandom));
            base = wr_cnt;
            drive_load(mode);
            wait_done(dcyc);
            n_tests++;
            if (done !== 1'b1 || cpu_rst !== 1'b0 || words_loaded !== 12'(n) || wr_cnt - base != n) begin
                n_fail++;
                $display("FAIL rand%0d_summary: done=%b cpu_rst=%b words_loaded=%0d writes=%0d, required 1 0 %0d %0d",
                         it, done, cpu_rst, words_loaded, wr_cnt - base, n, n);
            end else begin
                for (int unsigned i = 0; i < n; i++) begin
                    n_tests++;
                    if (log_addr[base+i] !== AW'(i) || log_data[base+i] !== payload[i] ||
                        log_cyc[base+i] != acc_log[i+1] + 1) begin
                        n_fail++;
                        $display("FAIL rand%0d_write%0d: addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                                 it, i, log_addr[base+i], log_data[base+i], log_cyc[base+i],
                                 i, payload[i], acc_log[i+1] + 1);
                    end
                end
                n_tests++;
                if (dcyc != acc_log[acc_log.size()-1] + DONE_LAT) begin
                    n_fail++;
                    $display("FAIL rand%0d_latency: done at cycle %0d, required %0d",
                             it, dcyc, acc_log[acc_log.size()-1] + DONE_LAT);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_backpressure();
        test_bad_header();
        test_restart();
        test_reset_midload();
        test_checksum();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
